fwd_source: RTL and testbench

FWD_SOURCE -- requirements
Module: fwd_source

---
 rtl/fwd_source_if.sv | 37 +++
 rtl/fwd_source.sv | 78 +++++++
 tb/tb_fwd_source.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fwd_source_if.sv
// Purpose: bundles the decode-side tag inputs, stage result inputs and
//          forwarding outputs of fwd_source into one port.
// Ports:   master drives decode/result signals; slave (fwd_source) drives
//          Forwarding_vector/Forwarding_data/Load_in_ex/err.
interface fwd_source_if;
    // Decode-stage instruction description
    logic [2:0]  Dec_reg_sel;
    logic        Dec_RegWrite;
    logic        Dec_ValidFwd;
    logic        Dec_MemRead;
    // Pipeline control
    logic        Stall;
    logic        Flush;
    // Per-stage result values
    logic [15:0] Ex_result;
    logic [15:0] Mem_result;
    logic [15:0] Wb_result;
    // Forwarding outputs
    logic [11:0] Forwarding_vector;
    logic [47:0] Forwarding_data;
    logic        Load_in_ex;
    logic        err;

    modport master (
        output Dec_reg_sel, Dec_RegWrite, Dec_ValidFwd, Dec_MemRead,
        output Stall, Flush,
        output Ex_result, Mem_result, Wb_result,
        input  Forwarding_vector, Forwarding_data, Load_in_ex, err
    );

    modport slave (
        input  Dec_reg_sel, Dec_RegWrite, Dec_ValidFwd, Dec_MemRead,
        input  Stall, Flush,
        input  Ex_result, Mem_result, Wb_result,
        output Forwarding_vector, Forwarding_data, Load_in_ex, err
    );
endinterface

// File: rtl/fwd_source.sv
// Purpose: tracks destination tags of instructions in execute/memory/writeback
//          and publishes them, with their result values, as forwarding sources.
// Latency: decode in cycle N -> execute entry N+1, memory N+2, writeback N+3;
//          data slices are combinational from the stage result inputs.
// Backpressure: Stall/Flush insert a bubble into execute; the back end never stalls.
// Ports: clk, rst (async active-high), bus (fwd_source_if.slave).
module fwd_source (
    input  logic          clk,
    input  logic          rst,
    fwd_source_if.slave   bus
);

    typedef struct packed {
        logic       valid;   // instruction writes a register and may forward
        logic       load;    // value only exists from the memory stage on
        logic [2:0] rd;      // destination register
    } tag_t;

    tag_t ex_tag;
    tag_t mem_tag;
    tag_t wb_tag;
    tag_t ex_next;
    logic err_q;
    logic err_next;
    logic ex_fwd;
    logic bubble;

    // A flush kills decode regardless of stall, so either one bubbles execute.
    assign bubble = bus.Stall | bus.Flush;

    always_comb begin
        ex_next  = '0;
        err_next = 1'b0;
        if (!bubble) begin
            ex_next.valid = bus.Dec_RegWrite & bus.Dec_ValidFwd;
            ex_next.load  = bus.Dec_MemRead;
            ex_next.rd    = bus.Dec_reg_sel;
            // A load that does not write the register file is malformed.
            err_next      = bus.Dec_MemRead & ~bus.Dec_RegWrite;
        end else if (bus.Stall && bus.Flush) begin
            // Decode cannot both hold and be killed in the same cycle.
            err_next      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag  <= '0;
            mem_tag <= '0;
            wb_tag  <= '0;
            err_q   <= 1'b0;
        end else begin
            ex_tag  <= ex_next;
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
            err_q   <= err_next;
        end
    end

    // A load in execute has no value yet, so the execute entry hides it,
    // including its register number, until it reaches memory.
    assign ex_fwd = ex_tag.valid & ~ex_tag.load;

    assign bus.Forwarding_vector[3]    = ex_fwd;
    assign bus.Forwarding_vector[2:0]  = ex_fwd ? ex_tag.rd : 3'b000;
    assign bus.Forwarding_vector[7]    = mem_tag.valid;
    assign bus.Forwarding_vector[6:4]  = mem_tag.rd;
    assign bus.Forwarding_vector[11]   = wb_tag.valid;
    assign bus.Forwarding_vector[10:8] = wb_tag.rd;

    assign bus.Forwarding_data[15:0]   = ex_fwd        ? bus.Ex_result  : 16'h0000;
    assign bus.Forwarding_data[31:16]  = mem_tag.valid ? bus.Mem_result : 16'h0000;
    assign bus.Forwarding_data[47:32]  = wb_tag.valid  ? bus.Wb_result  : 16'h0000;

    assign bus.Load_in_ex = ex_tag.valid & ex_tag.load;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_fwd_source.sv
// Purpose: directed self-checking bench for fwd_source.
// Drives inputs 1 time unit after each rising edge and checks outputs there.
// Summary line reports comparisons made and failures.
module tb_fwd_source;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fwd_source_if bus ();

    fwd_source dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rd, input logic rw, input logic vf,
                         input logic mr, input logic stall, input logic flush);
        bus.Dec_reg_sel  = rd;
        bus.Dec_RegWrite = rw;
        bus.Dec_ValidFwd = vf;
        bus.Dec_MemRead  = mr;
        bus.Stall        = stall;
        bus.Flush        = flush;
    endtask

    task automatic nop();
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [11:0] vec,
                              input logic [47:0] dat, input logic ld, input logic er);
        check({tag, ".vec"}, {52'h0, bus.Forwarding_vector}, {52'h0, vec});
        check({tag, ".dat"}, {16'h0, bus.Forwarding_data}, {16'h0, dat});
        check({tag, ".ld"},  {63'h0, bus.Load_in_ex}, {63'h0, ld});
        check({tag, ".err"}, {63'h0, bus.err}, {63'h0, er});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        nop();
        bus.Ex_result  = 16'h1111;
        bus.Mem_result = 16'h2222;
        bus.Wb_result  = 16'h3333;

        // Reset state
        tick();
        tick();
        check_outs("reset", 12'h000, 48'h0, 1'b0, 1'b0);
        rst = 1'b0;

        // ADD r3 travels execute -> memory -> writeback -> gone
        drive(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); nop();
        check_outs("add_ex",  12'h00B, 48'h0000_0000_1111, 1'b0, 1'b0);
        tick();
        check_outs("add_mem", 12'h0B0, 48'h0000_2222_0000, 1'b0, 1'b0);
        tick();
        check_outs("add_wb",  12'hB00, 48'h3333_0000_0000, 1'b0, 1'b0);
        tick();
        check_outs("add_gone", 12'h000, 48'h0, 1'b0, 1'b0);

        // LD r5 hidden in execute, visible from memory
        drive(3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); nop();
        check_outs("ld_ex",  12'h000, 48'h0, 1'b1, 1'b0);
        tick();
        check_outs("ld_mem", 12'h0D0, 48'h0000_2222_0000, 1'b0, 1'b0);
        tick();
        check_outs("ld_wb",  12'hD00, 48'h3333_0000_0000, 1'b0, 1'b0);
        tick();
        check_outs("ld_gone", 12'h000, 48'h0, 1'b0, 1'b0);

        // Stall: ADD r1 enters, then stalled ADD r2 becomes a bubble
        drive(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("pre_stall", 12'h009, 48'h0000_0000_1111, 1'b0, 1'b0);
        drive(3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); nop();
        check_outs("stall", 12'h090, 48'h0000_2222_0000, 1'b0, 1'b0);
        tick();
        check_outs("stall_adv", 12'h900, 48'h3333_0000_0000, 1'b0, 1'b0);
        tick();

        // Flush alone: bubble, no error
        drive(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); nop();
        check_outs("flush", 12'h000, 48'h0, 1'b0, 1'b0);

        // Stall and Flush together: bubble, err for one cycle
        drive(3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); nop();
        check_outs("stall_flush", 12'h000, 48'h0, 1'b0, 1'b1);
        tick();
        check({"stall_flush_clr", ".err"}, {63'h0, bus.err}, 64'h0);

        // LD without RegWrite: err next cycle, then clears
        drive(3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); nop();
        check("ld_norw.err", {63'h0, bus.err}, 64'h1);
        check("ld_norw.ld",  {63'h0, bus.Load_in_ex}, 64'h0);
        check("ld_norw.ex",  {60'h0, bus.Forwarding_vector[3:0]}, 64'h0);
        tick();
        check("ld_norw_clr.err", {63'h0, bus.err}, 64'h0);
        tick();
        tick();
        check_outs("drained", 12'h000, 48'h0, 1'b0, 1'b0);

        // Back-to-back JAL to r7 fills all three entries
        drive(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("jal1", 12'h00F, 48'h0000_0000_1111, 1'b0, 1'b0);
        tick();
        check_outs("jal2", 12'h0FF, 48'h0000_2222_1111, 1'b0, 1'b0);
        tick();
        check_outs("jal3", 12'hFFF, 48'h3333_2222_1111, 1'b0, 1'b0);

        // Different stage results prove slice routing
        bus.Ex_result  = 16'hA5A5;
        bus.Mem_result = 16'h5A5A;
        bus.Wb_result  = 16'hC3C3;
        #1;
        check("jal_data2", {16'h0, bus.Forwarding_data}, 64'h0000_C3C3_5A5A_A5A5);

        // Asynchronous reset between edges with all entries valid
        rst = 1'b1;
        #1;
        check_outs("arst_now", 12'h000, 48'h0, 1'b0, 1'b0);
        tick();
        check_outs("arst_held", 12'h000, 48'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_outs("post_rst", 12'h00F, 48'h0000_0000_A5A5, 1'b0, 1'b0);
        nop();
        tick();
        check("post_rst2.vec", {52'h0, bus.Forwarding_vector}, 64'h0F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
